// File: rtl/dht11_uart_formatter.sv
// dht11_uart_formatter
//
// Turns one DHT11 reading into the ASCII line
//   "H=<hum_int>.<hum_dec> T=<temp_int>.<temp_dec>" + terminator
// (or "ERR" + terminator when the reading failed its checksum) and streams
// it byte by byte into an 8N1 UART transmitter.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous, active-high
//   hum_int    humidity integer part
//   hum_dec    humidity decimal part
//   temp_int   temperature integer part
//   temp_dec   temperature decimal part
//   chk_err    checksum failure, qualified by rd_valid
//   rd_valid   one-cycle pulse, reading fields valid this cycle
//   tx_data    byte to the transmitter
//   tx_send    one-cycle send request to the transmitter
//   tx_busy    transmitter busy
//   fmt_busy   a line is being converted or sent
//   drop_cnt   readings ignored while busy, saturating at 255
//   state_dbg  current FSM state (IDLE=0 .. WAIT_LO=5)
//
// Transmitter handshake: tx_data is loaded in LOAD and stays constant until
// the next LOAD. tx_send is high for exactly the one SEND cycle. The
// transmitter answers by raising tx_busy the following cycle; the byte is
// complete once tx_busy has been seen high (WAIT_HI) and then low (WAIT_LO).
// tx_busy is never looked at while tx_send is high.

module dht11_uart_formatter #(
  parameter int CRLF = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       chk_err,
  input  logic       rd_valid,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  output logic       fmt_busy,
  output logic [7:0] drop_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    LOAD    = 3'd2,
    SEND    = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5
  } state_t;

  // The line is laid out on 22 fixed character slots; slots that do not
  // print (suppressed leading zeros, CR when CRLF=0, the number slots of an
  // ERR line) are marked invalid and skipped by the pointer.
  //   0 'H'  1 '='  2..4 hum_int  5 '.'  6..8 hum_dec  9 ' '
  //   10 'T' 11 '=' 12..14 temp_int 15 '.' 16..18 temp_dec 20 CR 21 LF
  localparam int NSLOT = 22;

  state_t      state_q, state_d;
  logic [7:0]  lat_field [4];
  logic        lat_err;
  logic [4:0]  cnt_q;
  logic [19:0] dd_q;
  logic [11:0] bcd_q [4];
  logic [4:0]  ptr_q;
  logic [7:0]  tx_data_q;
  logic [7:0]  drop_q;

  logic [7:0]  field_val;
  logic [19:0] dd_src, dd_adj, dd_next;
  logic [7:0]  slot_chr [NSLOT];
  logic        slot_vld [NSLOT];
  logic        nxt_found;
  logic [4:0]  nxt_ptr;

  function automatic int base_of(input int f);
    // first digit slot of field f: 2, 6, 12, 16
    return 2 + 4 * f + ((f >= 2) ? 2 : 0);
  endfunction

  // Double-dabble: {bcd[11:0], bin[7:0]} adjusted then shifted once per
  // cycle. The first cycle of a field starts from the raw latched byte.
  always_comb begin
    field_val = lat_field[cnt_q[4:3]];
    dd_src    = (cnt_q[2:0] == 3'd0) ? {12'd0, field_val} : dd_q;
    dd_adj    = dd_src;
    for (int d = 0; d < 3; d++) begin
      if (dd_src[8 + 4 * d +: 4] >= 4'd5) begin
        dd_adj[8 + 4 * d +: 4] = dd_src[8 + 4 * d +: 4] + 4'd3;
      end
    end
    dd_next = {dd_adj[18:0], 1'b0};
  end

  // Character table for the latched reading.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      slot_chr[i] = 8'h00;
      slot_vld[i] = 1'b0;
    end
    if (lat_err) begin
      slot_chr[0] = 8'h45; slot_vld[0] = 1'b1;  // E
      slot_chr[1] = 8'h52; slot_vld[1] = 1'b1;  // R
      slot_chr[2] = 8'h52; slot_vld[2] = 1'b1;  // R
    end else begin
      slot_chr[0]  = 8'h48; slot_vld[0]  = 1'b1;  // H
      slot_chr[1]  = 8'h3D; slot_vld[1]  = 1'b1;  // =
      slot_chr[5]  = 8'h2E; slot_vld[5]  = 1'b1;  // .
      slot_chr[9]  = 8'h20; slot_vld[9]  = 1'b1;  // space
      slot_chr[10] = 8'h54; slot_vld[10] = 1'b1;  // T
      slot_chr[11] = 8'h3D; slot_vld[11] = 1'b1;  // =
      slot_chr[15] = 8'h2E; slot_vld[15] = 1'b1;  // .
      for (int f = 0; f < 4; f++) begin
        slot_chr[base_of(f)]     = {4'h3, bcd_q[f][11:8]};
        slot_chr[base_of(f) + 1] = {4'h3, bcd_q[f][7:4]};
        slot_chr[base_of(f) + 2] = {4'h3, bcd_q[f][3:0]};
        // leading-zero suppression; the ones digit always prints
        slot_vld[base_of(f)]     = (bcd_q[f][11:8] != 4'd0);
        slot_vld[base_of(f) + 1] = (bcd_q[f][11:4] != 8'd0);
        slot_vld[base_of(f) + 2] = 1'b1;
      end
    end
    slot_chr[20] = 8'h0D; slot_vld[20] = (CRLF != 0);
    slot_chr[21] = 8'h0A; slot_vld[21] = 1'b1;
  end

  // Lowest printable slot above the current one.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ptr   = 5'd0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (slot_vld[i] && (5'(i) > ptr_q)) begin
        nxt_found = 1'b1;
        nxt_ptr   = 5'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_valid) state_d = chk_err ? LOAD : CONVERT;
      CONVERT: if (cnt_q == 5'd31) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    state_d = WAIT_HI;
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_d = nxt_found ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_err   <= 1'b0;
      cnt_q     <= 5'd0;
      dd_q      <= 20'd0;
      ptr_q     <= 5'd0;
      tx_data_q <= 8'h00;
      drop_q    <= 8'd0;
      for (int f = 0; f < 4; f++) begin
        lat_field[f] <= 8'd0;
        bcd_q[f]     <= 12'd0;
      end
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && rd_valid) begin
        lat_field[0] <= hum_int;
        lat_field[1] <= hum_dec;
        lat_field[2] <= temp_int;
        lat_field[3] <= temp_dec;
        lat_err      <= chk_err;
        cnt_q        <= 5'd0;
        ptr_q        <= 5'd0;
      end

      if (state_q != IDLE && rd_valid && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end

      if (state_q == CONVERT) begin
        cnt_q <= cnt_q + 5'd1;
        dd_q  <= dd_next;
        if (cnt_q[2:0] == 3'd7) begin
          bcd_q[cnt_q[4:3]] <= dd_next[19:8];
        end
      end

      if (state_q == LOAD) begin
        tx_data_q <= slot_chr[ptr_q];
      end

      if (state_q == WAIT_LO && !tx_busy && nxt_found) begin
        ptr_q <= nxt_ptr;
      end
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_send   = (state_q == SEND);
  assign fmt_busy  = (state_q != IDLE);
  assign drop_cnt  = drop_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dht11_uart_formatter.sv
// Bench for dht11_uart_formatter. Two instances (CRLF=1 and CRLF=0) share
// the reading fields; each has its own rd_valid and its own transmitter
// model (busy rises the cycle after a send and stays high 10 cycles).
// Byte timing per line: first send L0 cycles after the accepting edge
// (33, or 1 for ERR), then one byte every 13 cycles; fmt_busy drops
// L0 - 1 + 13*nbytes cycles after the accepting edge.

module tb_dht11_uart_formatter;

  localparam int NV = 7;

  typedef struct {
    logic [7:0]   hi;
    logic [7:0]   hd;
    logic [7:0]   ti;
    logic [7:0]   td;
    logic         err;
    logic [151:0] msg;
    int           len;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
  logic       chk_err;
  logic [1:0] rd_valid_w;
  logic [1:0] tx_send_w;
  logic [1:0] tx_busy_w;
  logic [1:0] fmt_busy_w;
  logic [7:0] tx_data_w [2];
  logic [7:0] drop_cnt_w [2];
  logic [2:0] state_dbg_w [2];
  int         bcnt [2];

  vec_t       vec [NV];
  logic [7:0] exp_q[$];
  int         exp_drop [2];
  int         total = 0;
  int         bad = 0;

  // ---------------- clock / DUTs / transmitter model ----------------
  always #5 clk = ~clk;

  dht11_uart_formatter #(.CRLF(1)) dut_crlf (
    .clk(clk), .reset(reset),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .chk_err(chk_err), .rd_valid(rd_valid_w[0]),
    .tx_data(tx_data_w[0]), .tx_send(tx_send_w[0]), .tx_busy(tx_busy_w[0]),
    .fmt_busy(fmt_busy_w[0]), .drop_cnt(drop_cnt_w[0]), .state_dbg(state_dbg_w[0])
  );

  dht11_uart_formatter #(.CRLF(0)) dut_lf (
    .clk(clk), .reset(reset),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .chk_err(chk_err), .rd_valid(rd_valid_w[1]),
    .tx_data(tx_data_w[1]), .tx_send(tx_send_w[1]), .tx_busy(tx_busy_w[1]),
    .fmt_busy(fmt_busy_w[1]), .drop_cnt(drop_cnt_w[1]), .state_dbg(state_dbg_w[1])
  );

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        tx_busy_w[i] <= 1'b0;
        bcnt[i]      <= 0;
      end else if (tx_send_w[i]) begin
        tx_busy_w[i] <= 1'b1;
        bcnt[i]      <= 10;
      end else if (bcnt[i] != 0) begin
        bcnt[i] <= bcnt[i] - 1;
        if (bcnt[i] == 1) tx_busy_w[i] <= 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic set_vec(input int idx, input int hi, input int hd, input int ti,
                         input int td, input bit err, input string s);
    vec[idx].hi  = 8'(hi);
    vec[idx].hd  = 8'(hd);
    vec[idx].ti  = 8'(ti);
    vec[idx].td  = 8'(td);
    vec[idx].err = err;
    vec[idx].len = s.len();
    vec[idx].msg = '0;
    for (int j = 0; j < s.len(); j++) vec[idx].msg[8 * (s.len() - 1 - j) +: 8] = s[j];
  endtask

  task automatic drive_fields(input int vi);
    hum_int  = vec[vi].hi;
    hum_dec  = vec[vi].hd;
    temp_int = vec[vi].ti;
    temp_dec = vec[vi].td;
    chk_err  = vec[vi].err;
  endtask

  task automatic rand_fields();
    hum_int  = 8'($urandom_range(0, 255));
    hum_dec  = 8'($urandom_range(0, 255));
    temp_int = 8'($urandom_range(0, 255));
    temp_dec = 8'($urandom_range(0, 255));
    chk_err  = 1'($urandom_range(0, 1));
  endtask

  task automatic start_msg(input int inst, input int vi);
    @(negedge clk);
    drive_fields(vi);
    rd_valid_w[inst] = 1'b1;
  endtask

  // Follows one line from its accepting edge. n_drop: rd_valid pulses fired
  // in the first n_drop busy cycles. chain_vi >= 0: pulse rd_valid in the
  // last busy cycle (dropped) and the first idle cycle (accepted, fields of
  // vector chain_vi), leaving the next line started.
  task automatic watch_msg(input int inst, input int vi, input int n_drop, input int chain_vi);
    int l0, nb, kf, k, first_k, fall_k, stab_bad, nsent;
    logic [7:0] b, last;
    l0 = vec[vi].err ? 1 : 33;
    exp_q.delete();
    for (int j = 0; j < vec[vi].len; j++) exp_q.push_back(vec[vi].msg[8 * (vec[vi].len - 1 - j) +: 8]);
    if (inst == 0) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    nb = exp_q.size();
    kf = l0 - 1 + 13 * nb;
    first_k = -1; fall_k = -1; stab_bad = 0; nsent = 0; last = 8'h00; k = 0;
    @(posedge clk);
    while (k <= kf || (fall_k < 0 && k < kf + 40)) begin
      @(negedge clk);
      if (chain_vi >= 0 && (k == kf - 1 || k == kf)) begin
        drive_fields(chain_vi);
        rd_valid_w[inst] = 1'b1;
      end else begin
        rand_fields();
        rd_valid_w[inst] = (k < n_drop);
      end
      if (k == 0) check($sformatf("busy_at_accept i%0d v%0d", inst, vi), int'(fmt_busy_w[inst]), 1);
      if (tx_send_w[inst]) begin
        if (first_k < 0) first_k = k;
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check($sformatf("byte%0d i%0d v%0d", nsent, inst, vi), int'(tx_data_w[inst]), int'(b));
        end
        last = tx_data_w[inst];
        nsent++;
      end
      if (tx_busy_w[inst] && tx_data_w[inst] != last) stab_bad++;
      if (k > 0 && !fmt_busy_w[inst] && fall_k < 0) fall_k = k;
      k++;
    end
    exp_drop[inst] = exp_drop[inst] + n_drop + ((chain_vi >= 0) ? 1 : 0);
    if (exp_drop[inst] > 255) exp_drop[inst] = 255;
    check($sformatf("first_send i%0d v%0d", inst, vi), first_k, l0);
    check($sformatf("nbytes i%0d v%0d", inst, vi), nsent, nb);
    check($sformatf("busy_fall i%0d v%0d", inst, vi), fall_k, kf);
    check($sformatf("data_stable i%0d v%0d", inst, vi), stab_bad, 0);
    check($sformatf("drop_cnt i%0d v%0d", inst, vi), int'(drop_cnt_w[inst]), exp_drop[inst]);
  endtask

  // ---------------- test ----------------
  initial begin
    int nsent, k;

    set_vec(0,  45,   0,  23,   0, 1'b0, "H=45.0 T=23.0");
    set_vec(1,   0,   0,   0,   0, 1'b0, "H=0.0 T=0.0");
    set_vec(2, 255, 255, 255, 255, 1'b0, "H=255.255 T=255.255");
    set_vec(3,  12,  34,  56,  78, 1'b1, "ERR");
    set_vec(4, 100,   5,   7,  99, 1'b0, "H=100.5 T=7.99");
    set_vec(5,  10,  90, 200,   1, 1'b0, "H=10.90 T=200.1");
    set_vec(6,   9, 250,  31, 106, 1'b0, "H=9.250 T=31.106");

    reset = 1'b1;
    rd_valid_w = 2'b00;
    hum_int = 8'd0; hum_dec = 8'd0; temp_int = 8'd0; temp_dec = 8'd0; chk_err = 1'b0;
    exp_drop[0] = 0;
    exp_drop[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_tx_send i%0d", i), int'(tx_send_w[i]), 0);
      check($sformatf("rst_tx_data i%0d", i), int'(tx_data_w[i]), 0);
      check($sformatf("rst_fmt_busy i%0d", i), int'(fmt_busy_w[i]), 0);
      check($sformatf("rst_drop_cnt i%0d", i), int'(drop_cnt_w[i]), 0);
      check($sformatf("rst_state i%0d", i), int'(state_dbg_w[i]), 0);
    end

    // table of readings, both terminator flavours
    for (int vi = 0; vi < NV; vi++) begin
      for (int inst = 0; inst < 2; inst++) begin
        start_msg(inst, vi);
        watch_msg(inst, vi, 0, -1);
      end
    end

    // back-to-back: pulse on the falling cycle is dropped, one later accepted
    for (int inst = 0; inst < 2; inst++) begin
      start_msg(inst, 1);
      watch_msg(inst, 1, 0, 4);
      watch_msg(inst, 4, 0, -1);
    end

    // 300 pulses while busy across two lines: 200 then 100, saturating
    for (int inst = 0; inst < 2; inst++) begin
      start_msg(inst, 2);
      watch_msg(inst, 2, 200, -1);
      start_msg(inst, 6);
      watch_msg(inst, 6, 100, -1);
    end

    // reset during byte 6 of a line, with rd_valid in the reset cycle
    start_msg(0, 0);
    @(posedge clk);
    nsent = 0;
    k = 0;
    while (nsent < 6 && k < 500) begin
      @(negedge clk);
      rd_valid_w[0] = 1'b0;
      if (tx_send_w[0]) nsent++;
      k++;
    end
    check("reached_byte6", nsent, 6);
    @(negedge clk);
    reset = 1'b1;
    rd_valid_w[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_valid_w[0] = 1'b0;
    exp_drop[0] = 0;
    exp_drop[1] = 0;
    check("mid_rst_tx_send", int'(tx_send_w[0]), 0);
    check("mid_rst_fmt_busy", int'(fmt_busy_w[0]), 0);
    check("mid_rst_drop_cnt", int'(drop_cnt_w[0]), 0);
    check("mid_rst_drop_cnt_lf", int'(drop_cnt_w[1]), 0);
    check("mid_rst_tx_data", int'(tx_data_w[0]), 0);
    nsent = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_send_w[0]) nsent++;
    end
    check("no_send_after_rst", nsent, 0);

    // normal operation after the abort
    start_msg(0, 5);
    watch_msg(0, 5, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
